wbuart_streamer: RTL and testbench

Wishbone master that drains a byte stream into the UART peripheral. Upstream logic (debug/trace output, test sequencers) pushes bytes over a valid/ready interface into a small internal FIFO. The block polls the UART TX FIFO status and writes each byte to the UART TX data register. It sits directly upstream of the UART wrapper on the user-area Wishbone bus.

---
 rtl/wbuart_streamer.sv | 169 ++++++++++++++++
 tb/tb_wbuart_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuart_streamer.sv
// Wishbone master that drains an upstream byte stream into a UART TX data register.
// Each byte is preceded by its own status poll; bus cycles abort on ack timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no bus activity; leaves for ST_POLL once the FIFO holds a byte
// ST_POLL  | status read at BASE_ADDR+0x4, waiting for ack
// ST_WAIT  | UART reported not ready; down-counter spaces the next poll
// ST_WRITE | data write of the FIFO head at BASE_ADDR+0xC, waiting for ack
module wbuart_streamer #(
    parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
    parameter int          FIFO_AW     = 3,
    parameter int          TX_RDY_BIT  = 0,
    parameter int          POLL_GAP    = 8,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               s_valid_i,
    input  logic [7:0]         s_data_i,
    output logic               s_ready_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [31:0]        wbm_adr_o,
    output logic [31:0]        wbm_dat_o,
    output logic [3:0]         wbm_sel_o,
    input  logic               wbm_ack_i,
    input  logic [31:0]        wbm_dat_i,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int                DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  FULL_LVL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [31:0]       STAT_ADDR = BASE_ADDR + 32'h4;
    localparam logic [31:0]       DATA_ADDR = BASE_ADDR + 32'hC;
    localparam logic [7:0]        GAP_LOAD  = 8'(POLL_GAP);
    localparam logic [7:0]        TMO_LOAD  = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POLL,
        ST_WAIT,
        ST_WRITE
    } state_t;

    state_t               state;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     level_nxt;
    logic [7:0]           gap_cnt;
    logic [7:0]           tmo_cnt;
    logic                 push;
    logic                 pop;
    logic                 unused_dat;

    // Only the ready bit of the status word matters.
    assign unused_dat = ^wbm_dat_i;

    assign push = s_valid_i & s_ready_o;
    assign pop  = (state == ST_WRITE) & wbm_cyc_o & wbm_ack_i;

    always_comb begin
        level_nxt = fifo_level_o;
        if (push && !pop) begin
            level_nxt = fifo_level_o + 1'b1;
        end else if (pop && !push) begin
            level_nxt = fifo_level_o - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
            s_ready_o    <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level_o <= level_nxt;
            s_ready_o    <= (level_nxt < FULL_LVL);
        end
    end

    // POLL and WRITE spend their first cycle with cyc low, which gives the
    // mandatory idle clock between back-to-back bus cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            busy_o <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fifo_level_o != '0) begin
                        state <= ST_POLL;
                    end else begin
                        busy_o <= (level_nxt != '0);
                    end
                end
                ST_POLL, ST_WRITE: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        wbm_we_o  <= (state == ST_WRITE);
                        wbm_adr_o <= (state == ST_WRITE) ? DATA_ADDR : STAT_ADDR;
                        wbm_dat_o <= (state == ST_WRITE) ? {24'h0, mem[rd_ptr]} : 32'h0;
                        tmo_cnt   <= TMO_LOAD;
                    end else if (wbm_ack_i || tmo_cnt == '0) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        wbm_adr_o <= '0;
                        wbm_dat_o <= '0;
                        if (!wbm_ack_i) begin
                            err_o  <= 1'b1;
                            state  <= ST_IDLE;
                            busy_o <= (level_nxt != '0);
                        end else if (state == ST_WRITE) begin
                            state  <= ST_IDLE;
                            busy_o <= (level_nxt != '0);
                        end else if (wbm_dat_i[TX_RDY_BIT]) begin
                            state <= ST_WRITE;
                        end else begin
                            state   <= ST_WAIT;
                            gap_cnt <= GAP_LOAD;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt == '0) begin
                        state <= ST_POLL;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbuart_streamer.sv
// Randomized bench for wbuart_streamer: a Wishbone slave model plus a byte-queue
// reference that tracks what the streamer must hold and write, in order.
module tb_wbuart_streamer;

    localparam logic [31:0] BASE  = 32'h3001_0000;
    localparam int          AW    = 3;
    localparam int          DEPTH = 8;
    localparam int          GAP   = 8;
    localparam int          TMO   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        ack;
    logic [AW:0] level;
    logic        busy, err;

    always #5 clk = ~clk;

    wbuart_streamer #(
        .BASE_ADDR(BASE), .FIFO_AW(AW), .TX_RDY_BIT(0), .POLL_GAP(GAP), .ACK_TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_sel_o(sel),
        .wbm_ack_i(ack), .wbm_dat_i(rdat),
        .fifo_level_o(level), .busy_o(busy), .err_o(err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  src_q[$];
    logic [7:0]  exp_q[$];
    int          push_prob, ack_dly_max, notready_left, notready_pct;
    bit          hold_writes, drop_writes;
    bit          in_cyc, acking, cur_we, ready_fresh, gap_pending, exp_err, pop_pending, saw_full;
    logic [31:0] cur_adr, cur_dat, last_wdat;
    int          wait_cnt, delay, cyc_len, idle_cnt, tmo_len, min_gap;
    int          n_reads, n_writes, n_timeouts, tick_no, push_tick, stb_tick;

    task automatic reset_model();
        src_q.delete();
        exp_q.delete();
        in_cyc = 0; acking = 0; ready_fresh = 0; gap_pending = 0; exp_err = 0;
        pop_pending = 0; idle_cnt = 0; ack = 1'b0; rdat = '0;
        hold_writes = 0; drop_writes = 0; notready_left = 0; notready_pct = 0;
    endtask

    task automatic slave_step();
        bit rdy;
        pop_pending = 0;
        if (acking) begin
            check_eq("ack_drop", {30'b0, cyc, stb}, 32'h0);
            ack = 1'b0; rdat = '0; acking = 0; in_cyc = 0;
            if (cur_we) check_eq("busy_after_write", busy, exp_q.size() != 0);
        end
        if (cyc) begin
            if (!in_cyc) begin
                in_cyc = 1; cur_we = we; cur_adr = adr; cur_dat = wdat;
                wait_cnt = 0; cyc_len = 0; delay = $urandom_range(ack_dly_max, 0);
                check_eq("adr", adr, we ? BASE + 32'hC : BASE + 32'h4);
                if (we) begin
                    check_eq("fresh_ready", ready_fresh, 1);
                    ready_fresh = 0;
                end else if (gap_pending) begin
                    if (idle_cnt < min_gap) min_gap = idle_cnt;
                    gap_pending = 0;
                end
                if (stb_tick < 0) stb_tick = tick_no;
            end
            check_eq("hold_ctl", {26'b0, stb, we, sel}, {26'b0, 1'b1, cur_we, 4'hF});
            check_eq("hold_adr", adr, cur_adr);
            check_eq("hold_dat", wdat, cur_dat);
            cyc_len++;
            if ((!cur_we || (!drop_writes && !hold_writes)) && wait_cnt >= delay) begin
                ack = 1'b1; acking = 1; idle_cnt = 0;
                if (!cur_we) begin
                    rdy = (notready_left == 0) && ($urandom_range(99, 0) >= notready_pct);
                    if (notready_left > 0) notready_left--;
                    rdat = $urandom;
                    rdat[0] = rdy;
                    ready_fresh = rdy; gap_pending = !rdy; n_reads++;
                end else begin
                    pop_pending = 1; n_writes++; last_wdat = cur_dat;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            check_eq("idle_bus", {27'b0, stb, sel}, 32'h0);
            if (in_cyc) begin
                tmo_len = cyc_len; n_timeouts++; exp_err = 1; in_cyc = 0; ready_fresh = 0;
            end
            idle_cnt++;
        end
        check_eq("err", err, exp_err);
    endtask

    task automatic drive_push();
        bit exp_ready, do_push;
        exp_ready = exp_q.size() < DEPTH;
        check_eq("s_ready", s_ready, exp_ready);
        check_eq("level", level, exp_q.size());
        if (!s_ready) saw_full = 1;
        do_push = 0;
        if (src_q.size() > 0 && $urandom_range(99, 0) < push_prob) begin
            s_valid = 1'b1;
            if (exp_ready) begin
                s_data = src_q[0];
                do_push = 1;
            end else begin
                s_data = 8'($urandom);
            end
        end else begin
            s_valid = 1'b0;
            s_data = 8'($urandom);
        end
        if (pop_pending) begin
            if (exp_q.size() == 0) begin
                check_eq("write_underflow", exp_q.size(), 1);
            end else begin
                check_eq("wdata", cur_dat, {24'h0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
        if (do_push) begin
            exp_q.push_back(src_q.pop_front());
            push_tick = tick_no;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tick_no++;
        slave_step();
        drive_push();
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        tick();
        while (!(src_q.size() == 0 && exp_q.size() == 0 && !cyc && !busy && !acking) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, n < budget, 1);
    endtask

    int r0, w0, b0;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        tick_no = 0; stb_tick = 0; push_tick = 0; n_reads = 0; n_writes = 0; n_timeouts = 0;
        push_prob = 100; ack_dly_max = 0; min_gap = 1000; saw_full = 0; tmo_len = 0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bus", {cyc, stb, we, sel}, 7'h0);
        check_eq("rst_adr", adr, 32'h0);
        check_eq("rst_dat", wdat, 32'h0);
        check_eq("rst_flags", {s_ready, busy, err}, 3'b100);
        check_eq("rst_level", level, 0);
        @(negedge clk);
        rst = 1'b0;

        // single byte, immediate acks
        r0 = n_reads; w0 = n_writes; stb_tick = -1;
        src_q.push_back(8'h41);
        run_idle("t1_drain", 200);
        check_eq("t1_latency", stb_tick - push_tick, 3);
        check_eq("t1_reads", n_reads - r0, 1);
        check_eq("t1_writes", n_writes - w0, 1);
        check_eq("t1_wdat", last_wdat, 32'h0000_0041);

        // burst of 10 into a depth-8 FIFO
        r0 = n_reads; w0 = n_writes; saw_full = 0; ack_dly_max = 2;
        for (int i = 0; i < 10; i++) src_q.push_back(8'(i));
        run_idle("t2_drain", 2000);
        check_eq("t2_writes", n_writes - w0, 10);
        check_eq("t2_full_seen", saw_full, 1);
        check_eq("t2_level", level, 0);

        // three not-ready polls before the UART accepts
        r0 = n_reads; w0 = n_writes; ack_dly_max = 0; min_gap = 1000; notready_left = 3;
        src_q.push_back(8'hA5);
        run_idle("t3_drain", 500);
        check_eq("t3_reads", n_reads - r0, 4);
        check_eq("t3_writes", n_writes - w0, 1);
        check_eq("t3_gap", min_gap >= GAP + 1, 1);

        // write never acked, then slave recovers
        r0 = n_reads; w0 = n_writes; b0 = 0; drop_writes = 1;
        src_q.push_back(8'h5A);
        while (n_timeouts == 0 && b0 < 300) begin
            tick();
            b0++;
        end
        check_eq("t4_timeout_seen", n_timeouts, 1);
        check_eq("t4_tmo_len", tmo_len, TMO);
        check_eq("t4_err", err, 1);
        drop_writes = 0;
        run_idle("t4_drain", 500);
        check_eq("t4_reads", n_reads - r0, 2);
        check_eq("t4_writes", n_writes - w0, 1);
        check_eq("t4_last", last_wdat, 32'h5A);
        check_eq("t4_err_sticky", err, 1);

        // push and pop on the same edge at level 5, then random traffic
        w0 = n_writes; b0 = 0; hold_writes = 1;
        for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
        while (!(in_cyc && cur_we && !acking && src_q.size() == 0) && b0 < 60) begin
            tick();
            b0++;
        end
        check_eq("t5_setup", b0 < 60, 1);
        check_eq("t5_level5", level, 5);
        hold_writes = 0;
        src_q.push_back(8'($urandom));
        tick();
        tick();
        check_eq("t5_simul", level, 5);
        push_prob = 40; ack_dly_max = 3; notready_pct = 25;
        for (int i = 0; i < 40; i++) src_q.push_back(8'($urandom));
        run_idle("t5_drain", 6000);
        check_eq("t5_writes", n_writes - w0, 46);

        // reset while a write with 4 queued bytes is on the bus
        push_prob = 100; ack_dly_max = 0; notready_pct = 0; hold_writes = 1; b0 = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
        while (!(in_cyc && cur_we && src_q.size() == 0) && b0 < 60) begin
            tick();
            b0++;
        end
        check_eq("t6_setup", {cyc, stb, we, level}, {3'b111, 4'd4});
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t6_bus", {cyc, stb}, 2'b00);
        check_eq("t6_level", level, 0);
        check_eq("t6_flags", {s_ready, busy, err}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        b0 = n_reads + n_writes;
        repeat (100) tick();
        check_eq("t6_quiet", n_reads + n_writes - b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
